stopwatch_bcd_timer: RTL
========================

STOPWATCH_BCD_TIMER -- requirements
Module: stopwatch_bcd_timer

Interface
REQ-001 The block SHALL have parameter DIV, default 1, meaning clk cycles per centisecond tick (legal 1..65535).
REQ-002 The block SHALL have parameter MAX_MIN, default 59, meaning the maximum minutes value (legal 1..99).
REQ-003 The block SHALL have parameter WRAP, default 1, meaning 1 = roll over to 00:00.00 at maximum, 0 = saturate at maximum.
REQ-004 clk  input  1  system clock (hz100 at top level); one clock, all state on rising edge.
REQ-005 nrst  input  1  reset, synchronous, active-low.
REQ-006 mode  input  3  one-hot mode from mode FSM: 3'b100 IDLE, 3'b001 RUNNING, 3'b010 CLEAR.
REQ-007 lap  input  1  synchronized lap button level.
REQ-008 cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi  output  4 each  displayed BCD digits (centiseconds, seconds, minutes; lo = ones, hi = tens), feeding ssdec.
REQ-009 frozen  output  1  1 when display shows the lap snapshot.
REQ-010 at_max  output  1  1 while the live count equals MAX_MIN:59.99.
REQ-011 wrapped  output  1  single-cycle pulse on rollover to 00:00.00.

Function
REQ-012 Mode decode: RUNNING = count; CLEAR = zero; IDLE and any non-one-hot encoding = hold.
REQ-013 Prescaler: counts 0..DIV-1 only in RUNNING; tick asserted in the cycle the prescaler equals DIV-1, which also wraps the prescaler to 0; DIV=1 gives tick every RUNNING cycle.
REQ-014 IDLE holds the prescaler value (no reset), so resuming continues the partial centisecond.
REQ-015 On tick the live count SHALL increment by 0.01 s, updating registers on the same edge (one-edge latency from tick cycle to new digits).
REQ-016 Carry chain: cs_lo 9->0 carries to cs_hi; cs_hi 9->0 carries to s_lo; s_lo 9->0 to s_hi; s_hi 5->0 to minutes; minutes (m_hi:m_lo) 0..MAX_MIN in BCD.
REQ-017 Every digit SHALL hold a legal BCD value at all times; no digit shall exceed 9 (s_hi never above 5).
REQ-018 At MAX_MIN:59.99 with tick and WRAP=1: next count 00:00.00 and wrapped=1 for exactly that next cycle.
REQ-019 At MAX_MIN:59.99 with tick and WRAP=0: count holds, wrapped stays 0, at_max stays 1.
REQ-020 at_max SHALL be a combinational compare of the live count registers.
REQ-021 CLEAR: synchronously zeroes live count, prescaler, lap snapshot and frozen on the next edge; CLEAR has priority over tick and lap.
REQ-022 Lap edge: a rising edge of lap is detected with one internal register (edge = lap & ~lap_q); lap held high produces a single event.
REQ-023 Lap event with frozen=0 and mode not CLEAR: snapshot of the live count captured, frozen=1 on the next edge; live count continues counting.
REQ-024 Lap event with frozen=1 and mode not CLEAR: frozen=0; snapshot unchanged.
REQ-025 Lap event in the same cycle as tick: snapshot captures the pre-increment value.
REQ-026 Display outputs SHALL show the snapshot when frozen=1, else the live count.
REQ-027 at_max and wrapped SHALL always reflect the live count, never the snapshot.

Reset
REQ-028 With nrst=0 on a rising edge: live count, snapshot, prescaler, lap_q, frozen and wrapped all 0; display 00:00.00.
REQ-029 Reset SHALL override mode and lap in the same cycle; assertion mid-count takes effect at the next edge.

Verification
REQ-030 DIV=1, RUNNING 100 cycles from reset -> display 00:01.00, at_max=0.
REQ-031 DIV=4, RUNNING 6 cycles, IDLE 10 cycles, RUNNING 2 cycles -> count 00:00.02 (prescaler held across IDLE).
REQ-032 MAX_MIN=1, WRAP=1, preload by running to 01:59.99, one tick -> 00:00.00, wrapped high one cycle; repeated with WRAP=0 -> holds 01:59.99, at_max=1, wrapped=0.
REQ-033 RUNNING at 00:00.37, lap pulse, run 50 more ticks -> display 00:00.37, frozen=1; second lap pulse -> display 00:00.87, frozen=0.
REQ-034 CLEAR and lap rise asserted together while frozen at 00:12.34 -> next cycle display 00:00.00, frozen=0, snapshot 0.
REQ-035 nrst=0 for one cycle while RUNNING at 00:59.99 -> next cycle all outputs 0; counting resumes from 00:00.00 after release.

Source files
------------

// File: rtl/stopwatch_bcd_timer.sv
// stopwatch_bcd_timer: BCD mm:ss.cc stopwatch with prescaler, lap freeze and wrap/saturate at maximum.
module stopwatch_bcd_timer #(
  parameter int DIV     = 1,
  parameter int MAX_MIN = 59,
  parameter int WRAP    = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] mode,
  input  logic       lap,
  output logic [3:0] cs_lo,
  output logic [3:0] cs_hi,
  output logic [3:0] s_lo,
  output logic [3:0] s_hi,
  output logic [3:0] m_lo,
  output logic [3:0] m_hi,
  output logic       frozen,
  output logic       at_max,
  output logic       wrapped
);
  localparam logic [15:0] PSC_TOP = 16'(DIV - 1);
  localparam logic [7:0]  MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  logic [15:0] r_psc;
  logic [23:0] r_live, r_snap, w_nxt;
  logic        r_lap_q, r_frozen, r_wrapped;
  logic        w_run, w_clr, w_tick, w_edge, w_hold;
  logic        w_c0, w_c1, w_c2, w_c3, w_c4;
  assign w_run  = mode == 3'b001;
  assign w_clr  = mode == 3'b010;
  assign w_tick = w_run && r_psc == PSC_TOP;
  assign w_edge = lap && !r_lap_q;
  assign at_max = r_live == {MAX_BCD, 16'h5999};
  assign w_hold = at_max && WRAP == 0;
  // Carry chain; live count is {m_hi, m_lo, s_hi, s_lo, cs_hi, cs_lo}
  always_comb begin
    w_c0 = r_live[3:0] == 4'd9;
    w_c1 = w_c0 && r_live[7:4] == 4'd9;
    w_c2 = w_c1 && r_live[11:8] == 4'd9;
    w_c3 = w_c2 && r_live[15:12] == 4'd5;
    w_c4 = w_c3 && r_live[19:16] == 4'd9;
    w_nxt[3:0]   = w_c0 ? 4'd0 : r_live[3:0] + 4'd1;
    w_nxt[7:4]   = !w_c0 ? r_live[7:4] : w_c1 ? 4'd0 : r_live[7:4] + 4'd1;
    w_nxt[11:8]  = !w_c1 ? r_live[11:8] : w_c2 ? 4'd0 : r_live[11:8] + 4'd1;
    w_nxt[15:12] = !w_c2 ? r_live[15:12] : w_c3 ? 4'd0 : r_live[15:12] + 4'd1;
    w_nxt[19:16] = !w_c3 ? r_live[19:16] : (at_max || w_c4) ? 4'd0 : r_live[19:16] + 4'd1;
    w_nxt[23:20] = at_max ? 4'd0 : w_c4 ? r_live[23:20] + 4'd1 : r_live[23:20];
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_psc     <= '0;
      r_live    <= '0;
      r_snap    <= '0;
      r_lap_q   <= 1'b0;
      r_frozen  <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_lap_q   <= lap;
      r_wrapped <= w_tick && at_max && WRAP != 0;
      if (w_clr) begin
        r_psc    <= '0;
        r_live   <= '0;
        r_snap   <= '0;
        r_frozen <= 1'b0;
      end else begin
        if (w_run) r_psc <= w_tick ? '0 : r_psc + 16'd1;
        if (w_tick && !w_hold) r_live <= w_nxt;
        // Snapshot takes the pre-increment value when lap and tick coincide
        if (w_edge) begin
          r_frozen <= !r_frozen;
          if (!r_frozen) r_snap <= r_live;
        end
      end
    end
  end
  assign {m_hi, m_lo, s_hi, s_lo, cs_hi, cs_lo} = r_frozen ? r_snap : r_live;
  assign frozen  = r_frozen;
  assign wrapped = r_wrapped;
endmodule
